// File: rtl/alu_calculator_pkg.sv
// Shared opcodes, seven-segment glyphs and display geometry for the ALU calculator.
package alu_calculator_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_NOT = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_DIV = 4'h9,
    OP_MOD = 4'hA,
    OP_CMP = 4'hB
  } opcode_e;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

endpackage

// File: rtl/alu_calculator_hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seven_seg
  import alu_calculator_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Map each nibble value onto its glyph
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      default: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/alu_calculator.sv
// 4-bit ALU with registered 8-bit result/overflow and a multiplexed
// 8-digit common-anode display of A, B, Opcode and the result.
module alu_calculator
  import alu_calculator_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] Opcode,
  output logic       overflow,
  output logic [7:0] anode,
  output logic [6:0] cathode
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [7:0]         r_result;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] r_digit;
  logic [7:0]         r_anode;
  logic [6:0]         r_cathode;

  logic [7:0]  w_a8;
  logic [7:0]  w_b8;
  logic [7:0]  w_sum;
  logic [7:0]  w_prod;
  logic [11:0] w_shl;
  logic [7:0]  w_alu_res;
  logic        w_alu_ovf;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_glyph;
  logic [6:0]  w_seg;

  assign w_a8   = {4'h0, A};
  assign w_b8   = {4'h0, B};
  assign w_sum  = w_a8 + w_b8;
  assign w_prod = w_a8 * w_b8;
  // Shift in 12 bits so overflow also sees bits pushed past the 8-bit result
  assign w_shl  = {8'h00, A} << B[2:0];

  // ALU operation select and overflow rules
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (Opcode)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (w_sum > 8'd15);
      end
      OP_SUB: begin
        w_alu_res = w_a8 - w_b8;
        w_alu_ovf = (A < B);
      end
      OP_MUL: begin
        w_alu_res = w_prod;
        w_alu_ovf = (w_prod > 8'd15);
      end
      OP_AND: w_alu_res = w_a8 & w_b8;
      OP_OR:  w_alu_res = w_a8 | w_b8;
      OP_XOR: w_alu_res = w_a8 ^ w_b8;
      OP_NOT: w_alu_res = {4'h0, ~A};
      OP_SHL: begin
        w_alu_res = w_shl[7:0];
        w_alu_ovf = |w_shl[11:4];
      end
      OP_SHR: w_alu_res = w_a8 >> B[2:0];
      OP_DIV: begin
        if (B == 4'h0) w_alu_ovf = 1'b1;
        else           w_alu_res = w_a8 / w_b8;
      end
      OP_MOD: begin
        if (B == 4'h0) w_alu_ovf = 1'b1;
        else           w_alu_res = w_a8 % w_b8;
      end
      OP_CMP: begin
        if (A > B)      w_alu_res = 8'h01;
        else if (A < B) w_alu_res = 8'hFF;
        else            w_alu_res = 8'h00;
      end
      default: w_alu_ovf = 1'b1;
    endcase
  end

  // Select the nibble shown on the digit currently being scanned
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (r_digit)
      3'd7: w_nib = A;
      3'd6: w_nib = B;
      3'd5: w_nib = Opcode;
      3'd1: w_nib = r_result[7:4];
      3'd0: w_nib = r_result[3:0];
      default: w_blank = 1'b1;
    endcase
  end

  hex_to_seven_seg u_hex_to_seven_seg (
    .i_hex (w_nib),
    .o_seg (w_glyph)
  );

  assign w_seg = w_blank ? SEG_BLANK : w_glyph;

  // Result register, scan timing and registered display pins
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_digit   <= '0;
      r_anode   <= '1;
      r_cathode <= SEG_BLANK;
    end else begin
      r_result <= w_alu_res;
      r_ovf    <= w_alu_ovf;
      if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_digit <= r_digit + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Anode and glyph come from the same digit index so they switch together
      r_anode   <= ~(8'b1 << r_digit);
      r_cathode <= w_seg;
    end
  end

  assign overflow = r_ovf;
  assign anode    = r_anode;
  assign cathode  = r_cathode;

endmodule

// File: tb/tb_alu_calculator.sv
// Self-checking bench for alu_calculator with a cycle-level reference model.
module tb_alu_calculator;

  localparam int unsigned DIV = 2;

  logic       clk;
  logic       reset;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Opcode;
  logic       overflow;
  logic [7:0] anode;
  logic [6:0] cathode;

  int unsigned tests_run;
  int unsigned tests_failed;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: edges since reset release, modelled result register, expected pins
  int unsigned n_edges;
  logic [7:0]  m_res;
  logic        m_ovf;
  logic [7:0]  exp_anode;
  logic [6:0]  exp_cath;

  alu_calculator #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .Opcode   (Opcode),
    .overflow (overflow),
    .anode    (anode),
    .cathode  (cathode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void alu_ref(input int a, input int b, input int op,
                                  output logic [7:0] res, output logic ovf);
    int r;
    r   = 0;
    ovf = 1'b0;
    case (op)
      0:  begin r = a + b; ovf = (r > 15); end
      1:  begin r = a - b; ovf = (a < b); end
      2:  begin r = a * b; ovf = (r > 15); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 15 - a;
      7:  begin r = a * (1 << (b % 8)); ovf = (r > 15); end
      8:  r = a / (1 << (b % 8));
      9:  if (b == 0) ovf = 1'b1; else r = a / b;
      10: if (b == 0) ovf = 1'b1; else r = a % b;
      11: r = (a > b) ? 1 : ((a == b) ? 0 : 255);
      default: ovf = 1'b1;
    endcase
    res = 8'(r & 255);
  endfunction

  function automatic logic [6:0] digit_ref(input int d, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] op,
                                           input logic [7:0] res);
    case (d)
      7: return glyph[a];
      6: return glyph[b];
      5: return glyph[op];
      1: return glyph[res[7:4]];
      0: return glyph[res[3:0]];
      default: return 7'h7F;
    endcase
  endfunction

  // One clock edge; model expectations use the values present at that edge
  task automatic step();
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [7:0] pre_res;
    logic       rst;
    int         d;
    a = A; b = B; op = Opcode; pre_res = m_res; rst = reset;
    @(posedge clk);
    if (!rst) begin
      n_edges   = 0;
      m_res     = 8'h00;
      m_ovf     = 1'b0;
      exp_anode = 8'hFF;
      exp_cath  = 7'h7F;
    end else begin
      d         = (n_edges / DIV) % 8;
      exp_anode = ~(8'h01 << d);
      exp_cath  = digit_ref(d, a, b, op, pre_res);
      alu_ref(int'(a), int'(b), int'(op), m_res, m_ovf);
      n_edges++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; A = 4'hF; B = 4'hF; Opcode = 4'h2;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (overflow !== 1'b0 || anode !== 8'hFF || cathode !== 7'h7F) begin
        tests_failed++;
        $display("FAIL reset_state: ovf=%b anode=%h cathode=%b, required ovf=0 anode=ff cathode=1111111",
                 overflow, anode, cathode);
      end
    end
    reset = 1'b1;
    step();
    tests_run++;
    if (anode !== 8'hFE) begin
      tests_failed++;
      $display("FAIL reset_release: anode=%h required fe", anode);
    end
  endtask

  task automatic test_directed();
    logic [3:0] t_a   [8] = '{4'hA, 4'h3, 4'h9, 4'h3, 4'h5, 4'h7, 4'h7, 4'h5};
    logic [3:0] t_b   [8] = '{4'hA, 4'h8, 4'h8, 4'h5, 4'h3, 4'h0, 4'h2, 4'h3};
    logic [3:0] t_op  [8] = '{4'h3, 4'h2, 4'h0, 4'h1, 4'h1, 4'h9, 4'h9, 4'hE};
    logic [7:0] t_res [8] = '{8'h0A, 8'h18, 8'h11, 8'hFE, 8'h02, 8'h00, 8'h03, 8'h00};
    logic       t_ovf [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      A = t_a[k]; B = t_b[k]; Opcode = t_op[k];
      r = t_res[k];
      for (int c = 0; c < 18; c++) begin
        step();
        tests_run++;
        if (overflow !== t_ovf[k]) begin
          tests_failed++;
          $display("FAIL directed_ovf[%0d]: got %b required %b", k, overflow, t_ovf[k]);
        end
        tests_run++;
        if (anode !== exp_anode || cathode !== exp_cath) begin
          tests_failed++;
          $display("FAIL directed_display[%0d]: anode=%h cathode=%b required anode=%h cathode=%b",
                   k, anode, cathode, exp_anode, exp_cath);
        end
        if (c >= 2 && anode == 8'hFE) begin
          tests_run++;
          if (cathode !== glyph[r[3:0]]) begin
            tests_failed++;
            $display("FAIL directed_res_lo[%0d]: cathode=%b required %b", k, cathode, glyph[r[3:0]]);
          end
        end
        if (c >= 2 && anode == 8'hFD) begin
          tests_run++;
          if (cathode !== glyph[r[7:4]]) begin
            tests_failed++;
            $display("FAIL directed_res_hi[%0d]: cathode=%b required %b", k, cathode, glyph[r[7:4]]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      Opcode = 4'($urandom_range(0, 15));
      step();
      tests_run++;
      if (overflow !== m_ovf || anode !== exp_anode || cathode !== exp_cath) begin
        tests_failed++;
        $display("FAIL random[%0d]: ovf=%b anode=%h cathode=%b required ovf=%b anode=%h cathode=%b",
                 i, overflow, anode, cathode, m_ovf, exp_anode, exp_cath);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    reset = 1'b0; A = 4'hC; B = 4'h4; Opcode = 4'h5;
    step();
    reset = 1'b1;
    for (int d = 0; d < 9; d++) begin
      for (int h = 0; h < 2; h++) begin
        step();
        tests_run++;
        if (anode !== seq[d % 8] || cathode !== exp_cath) begin
          tests_failed++;
          $display("FAIL scan[%0d.%0d]: anode=%h cathode=%b required anode=%h cathode=%b",
                   d, h, anode, cathode, seq[d % 8], exp_cath);
        end
      end
    end
    step();
    reset = 1'b0;
    step();
    tests_run++;
    if (anode !== 8'hFF || cathode !== 7'h7F || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL scan_reset: anode=%h cathode=%b ovf=%b required anode=ff cathode=1111111 ovf=0",
               anode, cathode, overflow);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if (anode !== 8'hFE) begin
      tests_failed++;
      $display("FAIL scan_restart: anode=%h required fe", anode);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_edges      = 0;
    m_res        = 8'h00;
    m_ovf        = 1'b0;
    exp_anode    = 8'hFF;
    exp_cath     = 7'h7F;
    reset        = 1'b0;
    A            = 4'h0;
    B            = 4'h0;
    Opcode       = 4'h0;
    test_reset();
    test_directed();
    test_random();
    test_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
